// File: rtl/vga_timing_gen_if.sv
// Timing-generator bundle: colour/enable in, coordinates, pulses and packed VGA bus out.
interface vga_timing_gen_if;
  logic        enable;
  logic [7:0]  RGBIn;
  logic [10:0] PixelX;
  logic [10:0] PixelY;
  logic        active;
  logic [18:0] address;
  logic        startOfFrame;
  logic        startOfLine;
  logic [15:0] frameCount;
  logic [28:0] oVGA;

  modport master (
    input  enable, RGBIn,
    output PixelX, PixelY, active, address, startOfFrame, startOfLine, frameCount, oVGA
  );

  modport slave (
    output enable, RGBIn,
    input  PixelX, PixelY, active, address, startOfFrame, startOfLine, frameCount, oVGA
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster counters with coordinate/pulse outputs; HS/VS/blank delayed PIPE_LAT clocks to line up with RGBIn.
// enable low freezes counters, frame counter and delay stages; pulses are suppressed while frozen.
module vga_timing_gen #(
  parameter int H_ACT    = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACT    = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 2
) (
  input logic           clk,
  input logic           resetN,
  vga_timing_gen_if.master vga
);

  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_BLANK + H_ACT;
  localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int V_TOTAL = V_BLANK + V_ACT;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_total_too_big
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_pipe_lat
      $error("vga_timing_gen: PIPE_LAT must be within 0..7");
    end
  endgenerate

  localparam logic [10:0] H_LAST_W  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST_W  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLANK_W = 11'(H_BLANK);
  localparam logic [10:0] V_BLANK_W = 11'(V_BLANK);
  localparam logic [10:0] H_SYB_W   = 11'(H_FRONT);
  localparam logic [10:0] H_SYE_W   = 11'(H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYB_W   = 11'(V_FRONT);
  localparam logic [10:0] V_SYE_W   = 11'(V_FRONT + V_SYNC);

  typedef struct packed {
    logic blank_n;
    logic vs;
    logic hs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{blank_n: 1'b0, vs: ~VS_POL, hs: ~HS_POL};

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [15:0] frame_cnt;
  logic        h_wrap;
  logic        v_wrap;
  logic        active_raw;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  sync_t       raw_s;
  sync_t       dly_s;

  assign h_wrap = (h_cnt == H_LAST_W);
  assign v_wrap = (v_cnt == V_LAST_W);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (vga.enable) begin
      if (h_wrap) begin
        h_cnt <= '0;
        if (v_wrap) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          v_cnt <= v_cnt + 11'd1;
        end
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  // Line/frame order is porch-sync-porch-active, so active starts at the blank width.
  assign active_raw = (h_cnt >= H_BLANK_W) && (v_cnt >= V_BLANK_W);
  assign pix_x      = active_raw ? (h_cnt - H_BLANK_W) : 11'd0;
  assign pix_y      = active_raw ? (v_cnt - V_BLANK_W) : 11'd0;

  assign raw_s.blank_n = active_raw;
  assign raw_s.hs      = ((h_cnt >= H_SYB_W) && (h_cnt < H_SYE_W)) ? HS_POL : ~HS_POL;
  assign raw_s.vs      = ((v_cnt >= V_SYB_W) && (v_cnt < V_SYE_W)) ? VS_POL : ~VS_POL;

  generate
    if (PIPE_LAT == 0) begin : g_direct
      assign dly_s = raw_s;
    end else begin : g_pipe
      sync_t stage [PIPE_LAT];

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < PIPE_LAT; i++) stage[i] <= SYNC_IDLE;
        end else if (vga.enable) begin
          stage[0] <= raw_s;
          for (int i = 1; i < PIPE_LAT; i++) stage[i] <= stage[i-1];
        end
      end

      assign dly_s = stage[PIPE_LAT-1];
    end
  endgenerate

  logic [2:0] r3;
  logic [2:0] g3;
  logic [1:0] b2;
  logic [7:0] r8;
  logic [7:0] g8;
  logic [7:0] b8;

  assign {r3, g3, b2} = vga.RGBIn;
  // Replicating the MSB stretches RGB332 so full-scale maps to 8'hFF.
  assign r8 = dly_s.blank_n ? {r3, {5{r3[2]}}} : 8'd0;
  assign g8 = dly_s.blank_n ? {g3, {5{g3[2]}}} : 8'd0;
  assign b8 = dly_s.blank_n ? {b2, {6{b2[1]}}} : 8'd0;

  assign vga.PixelX       = pix_x;
  assign vga.PixelY       = pix_y;
  assign vga.active       = active_raw;
  assign vga.address      = 19'(pix_y) * 19'(H_ACT) + 19'(pix_x);
  assign vga.startOfFrame = vga.enable && (h_cnt == 11'd0) && (v_cnt == 11'd0);
  assign vga.startOfLine  = vga.enable && (h_cnt == H_BLANK_W) && (v_cnt >= V_BLANK_W);
  assign vga.frameCount   = frame_cnt;
  assign vga.oVGA         = {~clk, dly_s.blank_n, 1'b1, dly_s.vs, dly_s.hs, r8, g8, b8};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small-raster DUTs (PIPE_LAT 0, PIPE_LAT 2, inverted sync) against a cycle model via a scoreboard queue.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HBL = HF + HS + HB, HT = HBL + HA;
  localparam int VBL = VF + VS + VB, VT = VBL + VA;
  localparam logic [2:0] DLY_IDLE = 3'b011;

  typedef struct {
    logic [10:0] px;
    logic [10:0] py;
    logic        act;
    logic [18:0] addr;
    logic        sof;
    logic        sol;
    logic [15:0] fc;
    logic [2:0]  sync0;
    logic [23:0] rgb0;
    logic [2:0]  sync2;
    logic [23:0] rgb2;
    logic [1:0]  syncp;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] rgb = 8'd0;
  int         tests = 0;
  int         fails = 0;
  int         h, v;
  logic [15:0] fc;
  int         sof_seen, sol_seen;
  exp_t       exp_q[$];
  logic [2:0] dly_q[$];

  always #5 clk = ~clk;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if2 ();
  vga_timing_gen_if ifp ();

  assign if0.enable = enable;
  assign if2.enable = enable;
  assign ifp.enable = enable;
  assign if0.RGBIn  = rgb;
  assign if2.RGBIn  = rgb;
  assign ifp.RGBIn  = rgb;

  vga_timing_gen #(.H_ACT(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(0))
    dut0 (.clk(clk), .resetN(resetN), .vga(if0));

  vga_timing_gen #(.H_ACT(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(2))
    dut2 (.clk(clk), .resetN(resetN), .vga(if2));

  vga_timing_gen #(.H_ACT(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_LAT(0))
    dutp (.clk(clk), .resetN(resetN), .vga(ifp));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] expand(input logic [7:0] c);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = c[7:5];
    g = c[4:2];
    b = c[1:0];
    return {r, {5{r[2]}}, g, {5{g[2]}}, b, {6{b[1]}}};
  endfunction

  function automatic exp_t predict(input logic en, input logic [7:0] c);
    exp_t e;
    logic hs0, vs0;
    int   x, y;
    e.act  = (h >= HBL) && (v >= VBL);
    x      = e.act ? h - HBL : 0;
    y      = e.act ? v - VBL : 0;
    e.px   = 11'(x);
    e.py   = 11'(y);
    e.addr = 19'(y * HA + x);
    e.sof  = en && (h == 0) && (v == 0);
    e.sol  = en && (h == HBL) && (v >= VBL);
    e.fc   = fc;
    hs0    = (h >= HF && h < HF + HS) ? 1'b0 : 1'b1;
    vs0    = (v >= VF && v < VF + VS) ? 1'b0 : 1'b1;
    e.sync0 = {e.act, vs0, hs0};
    e.rgb0  = e.act ? expand(c) : 24'd0;
    e.sync2 = dly_q[0];
    e.rgb2  = dly_q[0][2] ? expand(c) : 24'd0;
    e.syncp = {~vs0, ~hs0};
    return e;
  endfunction

  task automatic model_reset();
    h = 0;
    v = 0;
    fc = 16'd0;
    dly_q.delete();
    dly_q.push_back(DLY_IDLE);
    dly_q.push_back(DLY_IDLE);
  endtask

  // One pixel clock: drive on negedge, check mid-low-phase, then advance the model past the posedge.
  task automatic step(input logic en, input logic [7:0] c);
    exp_t e;
    @(negedge clk);
    enable = en;
    rgb    = c;
    exp_q.push_back(predict(en, c));
    #2;
    e = exp_q.pop_front();
    chk("PixelX",       32'(if0.PixelX),       32'(e.px));
    chk("PixelY",       32'(if0.PixelY),       32'(e.py));
    chk("active",       32'(if0.active),       32'(e.act));
    chk("address",      32'(if0.address),      32'(e.addr));
    chk("startOfFrame", 32'(if0.startOfFrame), 32'(e.sof));
    chk("startOfLine",  32'(if0.startOfLine),  32'(e.sol));
    chk("frameCount",   32'(if0.frameCount),   32'(e.fc));
    chk("sync_lat0",    32'(if0.oVGA[27:24]),  32'({e.sync0[2], 1'b1, e.sync0[1:0]}));
    chk("rgb_lat0",     32'(if0.oVGA[23:0]),   32'(e.rgb0));
    chk("sync_lat2",    32'(if2.oVGA[27:24]),  32'({e.sync2[2], 1'b1, e.sync2[1:0]}));
    chk("rgb_lat2",     32'(if2.oVGA[23:0]),   32'(e.rgb2));
    chk("sync_pol1",    32'(ifp.oVGA[25:24]),  32'(e.syncp));
    chk("clk_n_bit",    32'(if0.oVGA[28]),     32'd1);
    sof_seen += int'(if0.startOfFrame);
    sol_seen += int'(if0.startOfLine);
    if (en) begin
      dly_q.push_back(e.sync0);
      void'(dly_q.pop_front());
      if (h == HT - 1) begin
        h = 0;
        if (v == VT - 1) begin
          v  = 0;
          fc = fc + 16'd1;
        end else begin
          v++;
        end
      end else begin
        h++;
      end
    end
  endtask

  initial begin
    logic [7:0] c;
    logic       last;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_frameCount", 32'(if0.frameCount),  32'd0);
    chk("rst_startOfLine",32'(if0.startOfLine), 32'd0);
    chk("rst_active",     32'(if0.active),      32'd0);
    chk("rst_sync_lat0",  32'(if0.oVGA[27:24]), 32'b0111);
    chk("rst_sync_lat2",  32'(if2.oVGA[27:24]), 32'b0111);
    chk("rst_sync_pol1",  32'(ifp.oVGA[25:24]), 32'b00);
    resetN = 1'b1;

    // First full frame: colour pattern mixes full red, white and random values.
    sof_seen = 0;
    sol_seen = 0;
    for (int k = 0; k < VT * HT; k++) begin
      last = (h == HT - 1) && (v == VT - 1);
      case (k % 3)
        0:       c = 8'hE0;
        1:       c = 8'hFF;
        default: c = 8'($urandom);
      endcase
      step(1'b1, c);
      if (last) chk("address_last_pixel", 32'(if0.address), 32'd31);
    end
    chk("sof_per_frame", 32'(sof_seen), 32'd1);
    chk("sol_per_frame", 32'(sol_seen), 32'd4);

    // Freeze right on a startOfLine position.
    for (int n = 0; n < 2 * VT * HT && !(h == HBL && v == VBL); n++) step(1'b1, 8'hE0);
    sol_seen = 0;
    sof_seen = 0;
    repeat (5) step(1'b0, 8'h1C);
    chk("frozen_no_sol", 32'(sol_seen), 32'd0);
    chk("frozen_no_sof", 32'(sof_seen), 32'd0);
    step(1'b1, 8'h1C);
    chk("resume_sol", 32'(sol_seen), 32'd1);
    repeat (10) step(1'b1, 8'($urandom));

    // Preload frameCount to its maximum and watch it wrap at frame end.
    @(negedge clk);
    enable = 1'b0;
    force dut0.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut0.frame_cnt;
    fc = 16'hFFFF;
    for (int n = 0; n < 2 * VT * HT && !(h == 0 && v == 0); n++) step(1'b1, 8'($urandom));
    step(1'b1, 8'h03);
    chk("frameCount_wrap", 32'(if0.frameCount), 32'd0);

    // Mid-frame reset after one more completed frame.
    repeat (VT * HT + 20) step(1'b1, 8'($urandom));
    @(negedge clk);
    enable = 1'b0;
    resetN = 1'b0;
    #2;
    chk("midrst_frameCount",  32'(if0.frameCount),  32'd0);
    chk("midrst_active",      32'(if0.active),      32'd0);
    chk("midrst_startOfLine", 32'(if0.startOfLine), 32'd0);
    chk("midrst_sync_lat2",   32'(if2.oVGA[27:24]), 32'b0111);
    model_reset();
    resetN = 1'b1;
    sof_seen = 0;
    step(1'b1, 8'hE0);
    chk("post_rst_sof", 32'(sof_seen), 32'd1);
    repeat (30) step(1'b1, 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
